// File: rtl/state_dump_pkg.sv
// ============================================================================
// Module   : state_dump_pkg
// Brief    : Shared FSM state enum and constants for the state dump controller.
//            The register-phase states exist only when DUMP_REGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package state_dump_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_RD   = 3'd1,
    MEM_WAIT = 3'd2,
`ifdef DUMP_REGS_EN
    MEM_OUT  = 3'd3,
    RF_RD    = 3'd4,
    RF_WAIT  = 3'd5,
    RF_OUT   = 3'd6
`else
    MEM_OUT  = 3'd3
`endif
  } state_t;

  localparam logic TAG_MEM    = 1'b0;
  localparam logic TAG_RF     = 1'b1;
  localparam int   WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/dump_out_stage.sv
// ============================================================================
// Module   : dump_out_stage
// Brief    : Output holding register with valid/ready handshake for dumped words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dump_out_stage #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_tag,
  input  logic              i_last,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_valid,
  output logic              o_tag,
  output logic              o_last,
  output logic              o_accept
);

  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_tag;
  logic              r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_tag   <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_dout  <= i_data;
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      // Flags drop with valid so a stale last/tag is never visible.
      r_valid <= 1'b0;
      r_tag   <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_dout   = r_dout;
  assign o_valid  = r_valid;
  assign o_tag    = r_tag;
  assign o_last   = r_last;
  assign o_accept = r_valid & i_ready;

endmodule

`default_nettype wire

// File: rtl/state_dump_ctrl.sv
// ============================================================================
// Module   : state_dump_ctrl
// Brief    : One-shot PC-triggered dump of a memory window, then (optionally)
//            the register file. Macro DUMP_REGS_EN enables the register phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module state_dump_ctrl
  import state_dump_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BASE  = 256,
  parameter int MEM_WORDS = 64,
  parameter int NUM_REGS  = 32,
  parameter int TRIG_PC   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_arm,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_pc_valid,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rf_rd,
  output logic [4:0]        o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic              o_dout_tag,
  output logic              o_dout_last,
  output logic              o_busy,
  output logic              o_armed
);

  localparam int MAX_WORDS = (MEM_WORDS > NUM_REGS) ? MEM_WORDS : NUM_REGS;
  localparam int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              r_armed;
  logic              w_trigger;
  logic              w_accept;
  logic              w_mem_done;
  logic              w_load;
  logic              w_load_tag;
  logic              w_load_last;
  logic [DATA_W-1:0] w_load_data;

  assign w_trigger  = (r_state == IDLE) && r_armed && i_pc_valid &&
                      (i_pc == ADDR_W'(TRIG_PC));
  assign w_mem_done = (r_idx == IDX_W'(MEM_WORDS - 1));

`ifdef DUMP_REGS_EN
  logic w_rf_done;
  assign w_rf_done = (r_idx == IDX_W'(NUM_REGS - 1));
`else
  logic w_unused_rf;
  assign w_unused_rf = ^i_rf_rdata;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (i_arm)
        r_armed <= 1'b1;
      else if (w_trigger)
        r_armed <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_load_data = i_mem_rdata;
    w_load_tag  = TAG_MEM;
    w_load_last = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_addr  = '0;
    o_rf_rd     = 1'b0;
    o_rf_addr   = '0;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_state_nxt = MEM_RD;
          w_idx_nxt   = '0;
        end
      end
      MEM_RD: begin
        o_mem_rd    = 1'b1;
        o_mem_addr  = ADDR_W'(MEM_BASE) + ADDR_W'(r_idx) * ADDR_W'(WORD_BYTES);
        w_state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        w_load      = 1'b1;
`ifdef DUMP_REGS_EN
        w_load_last = 1'b0;
`else
        w_load_last = w_mem_done;
`endif
        w_state_nxt = MEM_OUT;
      end
      MEM_OUT: begin
        if (w_accept) begin
          if (!w_mem_done) begin
            w_state_nxt = MEM_RD;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end else begin
            w_idx_nxt   = '0;
`ifdef DUMP_REGS_EN
            w_state_nxt = RF_RD;
`else
            w_state_nxt = IDLE;
`endif
          end
        end
      end
`ifdef DUMP_REGS_EN
      RF_RD: begin
        o_rf_rd     = 1'b1;
        o_rf_addr   = 5'(r_idx);
        w_state_nxt = RF_WAIT;
      end
      RF_WAIT: begin
        w_load      = 1'b1;
        w_load_data = i_rf_rdata;
        w_load_tag  = TAG_RF;
        w_load_last = w_rf_done;
        w_state_nxt = RF_OUT;
      end
      RF_OUT: begin
        if (w_accept) begin
          w_idx_nxt   = w_rf_done ? '0 : r_idx + IDX_W'(1);
          w_state_nxt = w_rf_done ? IDLE : RF_RD;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  dump_out_stage #(
    .DATA_W (DATA_W)
  ) u_out (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .i_data   (w_load_data),
    .i_tag    (w_load_tag),
    .i_last   (w_load_last),
    .i_ready  (i_dout_ready),
    .o_dout   (o_dout),
    .o_valid  (o_dout_valid),
    .o_tag    (o_dout_tag),
    .o_last   (o_dout_last),
    .o_accept (w_accept)
  );

  assign o_busy  = (r_state != IDLE);
  assign o_armed = r_armed;

endmodule

`default_nettype wire

// File: tb/tb_state_dump_ctrl.sv
// ============================================================================
// Module   : tb_state_dump_ctrl
// Brief    : Directed self-checking bench for state_dump_ctrl (honours DUMP_REGS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_state_dump_ctrl;

  localparam int MEM_WORDS = 64;
  localparam int NUM_REGS  = 32;
`ifdef DUMP_REGS_EN
  localparam int N_WORDS = MEM_WORDS + NUM_REGS;
  localparam int N_RF    = NUM_REGS;
`else
  localparam int N_WORDS = MEM_WORDS;
  localparam int N_RF    = 0;
`endif

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        arm      = 1'b0;
  logic [31:0] pc       = '0;
  logic        pc_valid = 1'b0;
  logic        rdy      = 1'b1;
  logic        tog      = 1'b0;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;
  logic [31:0] rf_rdata  = 32'hDEAD_BEEF;

  logic        o_mem_rd, o_rf_rd, o_dout_valid, o_dout_tag, o_dout_last;
  logic        o_busy, o_armed;
  logic [31:0] o_mem_addr, o_dout;
  logic [4:0]  o_rf_addr;

  state_dump_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_arm        (arm),
    .i_pc         (pc),
    .i_pc_valid   (pc_valid),
    .o_mem_rd     (o_mem_rd),
    .o_mem_addr   (o_mem_addr),
    .i_mem_rdata  (mem_rdata),
    .o_rf_rd      (o_rf_rd),
    .o_rf_addr    (o_rf_addr),
    .i_rf_rdata   (rf_rdata),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (rdy),
    .o_dout_tag   (o_dout_tag),
    .o_dout_last  (o_dout_last),
    .o_busy       (o_busy),
    .o_armed      (o_armed)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory/RF model: data appears the cycle after the read strobe, garbage otherwise.
  logic        mem_pend = 1'b0, rf_pend = 1'b0;
  logic [31:0] mem_val = '0, rf_val = '0;
  always @(negedge clk) begin
    mem_rdata = mem_pend ? mem_val : 32'hDEAD_BEEF;
    rf_rdata  = rf_pend  ? rf_val  : 32'hDEAD_BEEF;
    mem_pend  = o_mem_rd;
    mem_val   = 32'h1000 + ((o_mem_addr - 32'd256) >> 2);
    rf_pend   = o_rf_rd;
    rf_val    = {27'd0, o_rf_addr};
  end

  logic [31:0] q_data[$];
  logic        q_tag[$];
  logic        q_last[$];
  logic [31:0] q_addr[$];
  int          rf_rd_cnt = 0;
  int          busy_cnt  = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = '0;
  logic        hold_tag  = 1'b0;
  logic        hold_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", {31'd0, o_dout_valid}, 32'd1);
        check("hold_data", o_dout, hold_data);
        check("hold_tag", {31'd0, o_dout_tag}, {31'd0, hold_tag});
        check("hold_last", {31'd0, o_dout_last}, {31'd0, hold_last});
      end
      if (o_dout_valid && rdy) begin
        q_data.push_back(o_dout);
        q_tag.push_back(o_dout_tag);
        q_last.push_back(o_dout_last);
      end
      hold_pend = o_dout_valid && !rdy;
      hold_data = o_dout;
      hold_tag  = o_dout_tag;
      hold_last = o_dout_last;
      if (o_mem_rd) q_addr.push_back(o_mem_addr);
      if (o_rf_rd)  rf_rd_cnt++;
      if (o_busy)   busy_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rdy = tog ? ~rdy : 1'b1;
  endtask

  task automatic clear_logs();
    q_data.delete();
    q_tag.delete();
    q_last.delete();
    q_addr.delete();
    rf_rd_cnt = 0;
    busy_cnt  = 0;
  endtask

  task automatic arm_and_trigger();
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("armed_after_arm", {31'd0, o_armed}, 32'd1);
    pc       = 32'd0;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
  endtask

  // action 1: retrigger + arm at cycle `hook`; action 2: async reset at cycle `hook`.
  task automatic run_dump(input int hook, input int action, output int cycles);
    int k;
    k = 1;
    while (k < 3000) begin
      if (k == hook && action == 1) begin
        pc_valid = 1'b1;
        arm      = 1'b1;
      end
      if (k == hook && action == 2) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_valid", {31'd0, o_dout_valid}, 32'd0);
        check("rst_mem_rd", {31'd0, o_mem_rd}, 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_dout", o_dout, 32'd0);
        check("rst_last", {31'd0, o_dout_last}, 32'd0);
        check("rst_tag", {31'd0, o_dout_tag}, 32'd0);
        check("rst_armed", {31'd0, o_armed}, 32'd0);
        check("rst_rf_rd", {31'd0, o_rf_rd}, 32'd0);
        cycles = k;
        return;
      end
      step();
      pc_valid = 1'b0;
      arm      = 1'b0;
      if (!o_busy) break;
      k++;
    end
    if (k >= 3000) check("dump_timeout", 32'd0, 32'd1);
    cycles = k;
  endtask

  task automatic verify_dump();
    int n;
    check("n_words", q_data.size(), N_WORDS);
    n = (q_data.size() < N_WORDS) ? q_data.size() : N_WORDS;
    for (int i = 0; i < n; i++) begin
      if (i < MEM_WORDS) begin
        check("mem_data", q_data[i], 32'h1000 + i);
        check("mem_tag", {31'd0, q_tag[i]}, 32'd0);
      end else begin
        check("rf_data", q_data[i], i - MEM_WORDS);
        check("rf_tag", {31'd0, q_tag[i]}, 32'd1);
      end
      check("last_flag", {31'd0, q_last[i]}, (i == N_WORDS - 1) ? 32'd1 : 32'd0);
    end
    check("n_mem_rd", q_addr.size(), MEM_WORDS);
    if (q_addr.size() == MEM_WORDS) begin
      check("first_addr", q_addr[0], 32'd256);
      check("last_addr", q_addr[MEM_WORDS-1], 32'd508);
    end
    check("n_rf_rd", rf_rd_cnt, N_RF);
  endtask

  initial begin
    int cyc;

    // Reset state
    step();
    step();
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_armed", {31'd0, o_armed}, 32'd0);
    check("reset_valid", {31'd0, o_dout_valid}, 32'd0);
    check("reset_dout", o_dout, 32'd0);
    check("reset_mem_rd", {31'd0, o_mem_rd}, 32'd0);
    rst_n = 1'b1;
    step();

    // Trigger without arm
    clear_logs();
    pc       = 32'd0;
    pc_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    pc_valid = 1'b0;
    step();
    check("noarm_mem_rd", q_addr.size(), 32'd0);
    check("noarm_busy", busy_cnt, 32'd0);

    // Full dump, ready held high
    clear_logs();
    arm_and_trigger();
    run_dump(0, 0, cyc);
    check("dump_cycles", cyc, 3 * N_WORDS);
    verify_dump();
    check("armed_cleared", {31'd0, o_armed}, 32'd0);

    // Ready toggling every cycle
    step();
    clear_logs();
    tog = 1'b1;
    arm_and_trigger();
    run_dump(0, 0, cyc);
    tog = 1'b0;
    step();
    verify_dump();

    // Retrigger and re-arm while busy
    clear_logs();
    arm_and_trigger();
    run_dump(50, 1, cyc);
    check("retrig_cycles", cyc, 3 * N_WORDS);
    for (int i = 0; i < 6; i++) step();
    verify_dump();
    check("rearmed_after", {31'd0, o_armed}, 32'd1);
    check("no_second_dump", {31'd0, o_busy}, 32'd0);

    // Reset in the middle of a dump, then restart
    clear_logs();
    arm_and_trigger();
    run_dump(40, 2, cyc);
    step();
    check("rst_hold_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    step();
    clear_logs();
    arm_and_trigger();
    run_dump(0, 0, cyc);
    check("restart_cycles", cyc, 3 * N_WORDS);
    verify_dump();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/state_dump_ctrl.md
STATE_DUMP_CTRL -- requirements
Module: state_dump_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 32, memory/register word width
- ADDR_W, 32, PC and memory address width
- MEM_BASE, 256, first byte address dumped
- MEM_WORDS, 64, number of memory words dumped
- NUM_REGS, 32, register-file entries dumped
- TRIG_PC, 0, PC value that fires the dump

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1, the block's only clock
- i_rst_n, in, 1, asynchronous active-low reset
- i_arm, in, 1, one-cycle pulse that arms a one-shot dump
- i_pc, in, ADDR_W, current processor PC
- i_pc_valid, in, 1, i_pc is meaningful this cycle
- o_mem_rd, out, 1, memory read strobe
- o_mem_addr, out, ADDR_W, byte address of the read
- i_mem_rdata, in, DATA_W, read data, one cycle after o_mem_rd
- o_rf_rd, out, 1, register-file read strobe
- o_rf_addr, out, 5, register index
- i_rf_rdata, in, DATA_W, register data, one cycle after o_rf_rd
- o_dout, out, DATA_W, dumped word
- o_dout_valid, out, 1, o_dout is valid
- i_dout_ready, in, 1, the sink accepts the word
- o_dout_tag, out, 1, word source: 0 = memory, 1 = register
- o_dout_last, out, 1, final word of the dump
- o_busy, out, 1, a dump is in progress
- o_armed, out, 1, the block is armed and waiting for the trigger

Function
REQ-003 The FSM SHALL have the states IDLE, MEM_RD, MEM_WAIT, MEM_OUT, RF_RD, RF_WAIT, RF_OUT.
REQ-004 i_arm SHALL set the armed flag from any state; the flag SHALL clear when the dump starts.
REQ-005 The trigger SHALL be: IDLE, armed, i_pc_valid and i_pc==TRIG_PC, all in one cycle. On the next clock edge the FSM SHALL move to MEM_RD with the index at 0.
REQ-006 In MEM_RD the block SHALL drive o_mem_rd=1 and o_mem_addr=MEM_BASE+4*index for exactly one cycle, then move to MEM_WAIT.
REQ-007 In MEM_WAIT the block SHALL capture i_mem_rdata into the output register and move to MEM_OUT.
REQ-008 In MEM_OUT the block SHALL hold o_dout_valid=1 with o_dout, o_dout_tag and o_dout_last stable until a cycle with i_dout_ready=1.
REQ-009 After that handshake, the next state SHALL be:
- MEM_RD with index+1 if index<MEM_WORDS-1
- otherwise RF_RD with index 0, or IDLE if registers are excluded (REQ-017)
REQ-010 RF_RD, RF_WAIT and RF_OUT SHALL mirror REQ-006 to REQ-009, using o_rf_rd, o_rf_addr=index and i_rf_rdata, with tag=1. After the handshake on index NUM_REGS-1 the FSM SHALL return to IDLE.
REQ-011 o_dout_last SHALL be 1 only on the final word of the dump.
REQ-012 With i_dout_ready held at 1, the dump SHALL produce one word every 3 cycles. Total dump SHALL be 3*(MEM_WORDS+NUM_REGS) cycles from trigger to IDLE.
REQ-013 A trigger condition seen while o_busy=1 SHALL be ignored. i_arm while busy SHALL re-arm the block for a later dump.
REQ-014 Address arithmetic SHALL be modulo 2^ADDR_W; wrap-around SHALL NOT be flagged.
REQ-015 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-016 When i_rst_n=0 the block SHALL immediately force:
- FSM to IDLE
- armed=0, index=0
- o_dout=0, and every output strobe and flag to 0
Reset during a dump SHALL abort it with no partial valid.

Configuration
REQ-017 With DUMP_REGS_EN defined, the register phase SHALL be included. Without it:
- the RF states SHALL not exist
- o_rf_rd and o_rf_addr SHALL be tied to 0
- o_dout_last SHALL assert on memory word MEM_WORDS-1
- the dump SHALL last 3*MEM_WORDS cycles

Structure
REQ-018 The package state_dump_pkg SHALL hold the FSM state enum, the TAG_MEM and TAG_RF constants, and the word-size constant 4.
REQ-019 The output holding register and handshake SHALL be one sub-module, dump_out_stage.

Verification
REQ-020 Arm, then PC=0 valid, ready=1, memory word i = 0x1000+i, register r = r:
- 96 words appear in order
- tags are 0 then 1
- last asserts only on register 31
- done in 288 cycles
REQ-021 Trigger PC=0 with no arm: no o_mem_rd and o_busy stays 0.
REQ-022 Ready toggles 1/0 each cycle: every word is held stable while ready=0, no word is lost or duplicated, and the data order matches REQ-020.
REQ-023 Second PC=0 trigger at cycle 50 of a dump: ignored, the dump completes once. An i_arm at cycle 50 leaves o_armed=1 after the dump.
REQ-024 Reset pulse at cycle 40 of a dump: all outputs go to 0 at once, the FSM returns to IDLE, and a new arm plus trigger restarts at address 256.
REQ-025 Build without DUMP_REGS_EN: exactly 64 words, last on address 508, o_rf_rd never 1.
